ram_queue: RTL and testbench
============================

Name: ram_queue

Overview:
- Parametrised synchronous FIFO queue backed by an internal two-port RAM array; generalises the 1 kB byte-wide RAM to configurable width and depth.
- Separate input and output data buses instead of a shared tri-state bus.
- Adds full/empty/almost flags, occupancy count, sticky error flags and flush.
- Sits between a byte/word producer and consumer wherever the design needs queued buffering.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W entries (default 1024 x 8 = 1 kB).
- AFULL_TH, 1020, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request; din is written when the push is accepted.
- din  in  DATA_W  write data.
- pop  in  1  read request.
- dout  out  DATA_W  read data, registered.
- dout_valid  out  1  one-cycle pulse: dout holds the word from the previous accepted pop.
- flush  in  1  synchronous clear of queue contents and error flags.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Therefore empty=1, almost_empty=1, full=0, almost_full=0.
- RAM contents are not reset.
- All flags are decoded from the registered count, so they are glitch-free and update in the cycle after the causing edge.
- pop_acc = pop & ~empty.
- push_acc = push & (~full | pop_acc). When full, a simultaneous pop frees a slot, so both are accepted.
- Empty with push & pop: pop is rejected (underflow set) and push is accepted. There is no fall-through.
- count_next = count + push_acc - pop_acc. Simultaneous accepted push and pop leave count unchanged.
- Pointers are ADDR_W bits and wrap modulo DEPTH with no special case. Each pointer increments only on its accepted event.
- RAM is read-first. When full with push & pop, rd_ptr == wr_ptr; the read returns the old word and the new word is written.
- Read latency is 1 cycle. An accepted pop at edge N gives dout = mem[rd_ptr] and dout_valid=1 after edge N.
- dout holds its value when there is no accepted pop; dout_valid is then 0.
- overflow: set on push & ~push_acc. underflow: set on pop & ~pop_acc. Both stay set until flush or reset.
- flush (synchronous) has priority over push and pop in the same cycle. It zeroes pointers, count, overflow and underflow, and forces dout_valid=0. dout keeps its last value.
- Reset mid-operation: immediate return to the reset state; queued data is lost.

Decomposition:
- Shared package (queue_pkg): DEPTH derivation from ADDR_W, and default DATA_W/ADDR_W constants shared with other queue users.
- One sub-module: queue_ram_2p(clk, we, waddr, wdata, re, raddr, rdata).
  - Array of DEPTH x DATA_W words, one write port and one registered read port.
  - Read-first on an address collision.
  - No reset on the array.
- All control (pointers, count, flags) lives in ram_queue.

Test Plan:
- Reset/idle: hold rst_n=0, then release. Expect empty=1, almost_empty=1, full=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- Ordering and latency (defaults): push 0x11, 0x22, 0x33, then pop x3. Expect count to step 1, 2, 3 then 2, 1, 0. dout_valid pulses one cycle after each pop with dout = 0x11, 0x22, 0x33 in order.
- Full, overflow and wrap (ADDR_W=3, AFULL_TH=6, AEMPTY_TH=1):
  - Push 0..7: almost_full=1 at count 6, full=1 at count 8.
  - Push 0xAA while full: ignored, overflow=1, count stays 8.
  - Pop 8: expect 0..7 in order. Push and pop again so both pointers wrap past 7; order is preserved.
- Simultaneous at full (ADDR_W=3): fill with 0..7, then push 0x55 & pop in the same cycle. Expect dout=0x00, count=8, overflow=0. Draining returns 1..7 then 0x55.
- Simultaneous at empty: push 0x99 & pop with count=0. Expect underflow=1, count=1, dout_valid=0. The next pop returns dout=0x99.
- Flush and async reset:
  - With count=5 and overflow=1, assert flush together with push & pop. Expect count=0, empty=1, overflow=0, dout_valid=0 next cycle.
  - Assert rst_n=0 mid-burst between clock edges. Outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared constants for queue users: default word/address widths and
// the depth derivation from an address width.
package queue_pkg;

  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_ADDR_W = 10;

  // Number of entries addressable by an addr_w-bit pointer.
  function automatic int queue_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/queue_ram_2p.sv
// Two-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
// The array and the read register carry no reset.
module queue_ram_2p
  import queue_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int ADDR_W = QUEUE_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = queue_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; non-blocking semantics give read-first on collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_queue.sv
// Synchronous FIFO built on queue_ram_2p. Pointers, occupancy count,
// status flags and sticky error flags live here; all flags decode from
// the registered count.
module ram_queue
  import queue_pkg::*;
#(
  parameter int DATA_W    = QUEUE_DATA_W,
  parameter int ADDR_W    = QUEUE_ADDR_W,
  parameter int AFULL_TH  = 1020,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int             DEPTH    = queue_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, underflow_reg;
  logic              dout_valid_reg;
  // Set after the first read so dout shows zero until real data exists,
  // since the RAM read register itself has no reset.
  logic              dout_loaded_reg;
  logic [DATA_W-1:0] ram_rdata;

  logic pop_acc, push_acc, ram_we, ram_re;

  // Accept logic; flush suppresses both RAM accesses.
  always_comb begin
    pop_acc  = pop & ~empty;
    push_acc = push & (~full | pop_acc);
    ram_we   = push_acc & ~flush;
    ram_re   = pop_acc & ~flush;
    count_next = count_reg + {{ADDR_W{1'b0}}, push_acc} - {{ADDR_W{1'b0}}, pop_acc};
  end

  // Flags decoded from the registered count.
  always_comb begin
    full         = (count_reg == DEPTH_C);
    empty        = (count_reg == '0);
    almost_full  = (count_reg >= AFULL_C);
    almost_empty = (count_reg <= AEMPTY_C);
  end

  // Pointer, count and sticky-flag state; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      dout_valid_reg  <= 1'b0;
      dout_loaded_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      overflow_reg   <= overflow_reg | (push & ~push_acc);
      underflow_reg  <= underflow_reg | (pop & ~pop_acc);
      dout_valid_reg <= pop_acc;
      if (pop_acc) dout_loaded_reg <= 1'b1;
    end
  end

  queue_ram_2p #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_reg),
    .wdata(din),
    .re   (ram_re),
    .raddr(rd_ptr_reg),
    .rdata(ram_rdata)
  );

  assign dout       = dout_loaded_reg ? ram_rdata : '0;
  assign dout_valid = dout_valid_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_ram_queue.sv
// Scoreboard bench for ram_queue with a small configuration (8 entries)
// so full, wrap and the thresholds are reached quickly.
module tb_ram_queue;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  bit            m_ov, m_un, m_valid;
  logic [DW-1:0] m_dout;

  ram_queue #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .flush(flush),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ov = 0; m_un = 0; m_valid = 0; m_dout = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_un));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
  endtask

  // One clock of stimulus; the model advances from the queue rules.
  task automatic cycle(input string tag, input bit p, input logic [DW-1:0] d,
                       input bit q, input bit f);
    bit pop_ok, push_ok;
    push = p; din = d; pop = q; flush = f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_ov = 0; m_un = 0; m_valid = 0;
    end else begin
      pop_ok  = q && (mq.size() > 0);
      push_ok = p && ((mq.size() < DEPTH) || pop_ok);
      m_valid = pop_ok;
      if (pop_ok) begin
        m_dout = mq.pop_front();
        sb.push_back(m_dout);
      end
      if (push_ok) mq.push_back(d);
      if (p && !push_ok) m_ov = 1;
      if (q && !pop_ok) m_un = 1;
    end
    #1;
    push = 0; pop = 0; flush = 0;
    check_all(tag);
  endtask

  // Monitor: every presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", dout);
      end else begin
        automatic logic [DW-1:0] e = sb.pop_front();
        check("sb_dout", 32'(dout), 32'(e));
        $display("pop word dout=%02h expected=%02h", dout, e);
      end
    end
  end

  initial begin
    model_reset();
    // Reset / idle.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cycle("idle", 0, 8'h00, 0, 0);

    // Ordering and latency.
    cycle("ord_push", 1, 8'h11, 0, 0);
    cycle("ord_push", 1, 8'h22, 0, 0);
    cycle("ord_push", 1, 8'h33, 0, 0);
    repeat (3) cycle("ord_pop", 0, 8'h00, 1, 0);
    cycle("ord_idle", 0, 8'h00, 0, 0);

    // Fill, overflow, drain, wrap.
    for (int i = 0; i < 8; i++) cycle("fill", 1, 8'(i), 0, 0);
    cycle("ovf_push", 1, 8'hAA, 0, 0);
    for (int i = 0; i < 8; i++) cycle("drain", 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cycle("wrap_push", 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 5; i++) cycle("wrap_pop", 0, 8'h00, 1, 0);

    // Simultaneous push and pop at full.
    for (int i = 0; i < 8; i++) cycle("fill2", 1, 8'(i), 0, 0);
    cycle("full_pp", 1, 8'h55, 1, 0);
    for (int i = 0; i < 8; i++) cycle("drain2", 0, 8'h00, 1, 0);

    // Simultaneous push and pop at empty.
    cycle("empty_pp", 1, 8'h99, 1, 0);
    cycle("empty_pop", 0, 8'h00, 1, 0);

    // Flush with count=5 and overflow still set, plus push & pop.
    for (int i = 0; i < 5; i++) cycle("pre_flush", 1, 8'(8'h60 + i), 0, 0);
    cycle("flush", 1, 8'h77, 1, 1);
    cycle("post_flush", 0, 8'h00, 0, 0);

    // Randomised traffic with shifting push/pop bias.
    for (int seg = 0; seg < 12; seg++) begin
      automatic int pp = (seg % 3 == 0) ? 85 : ((seg % 3 == 1) ? 20 : 55);
      for (int i = 0; i < 120; i++) begin
        cycle("rand",
              ($urandom_range(99) < pp),
              8'($urandom),
              ($urandom_range(99) < (100 - pp)),
              ($urandom_range(99) < 2));
      end
    end

    // Asynchronous reset mid-burst, between clock edges.
    for (int i = 0; i < 4; i++) cycle("burst", 1, 8'(8'hC0 + i), 0, 0);
    push = 1; din = 8'hCC;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push = 0;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    cycle("after_rst", 1, 8'hE1, 0, 0);
    cycle("after_rst_pop", 0, 8'h00, 1, 0);
    cycle("final_idle", 0, 8'h00, 0, 0);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
